fetch_pc_stage: RTL and testbench
=================================

# fetch_pc_stage

Program-counter and IF/ID pipeline-register stage of the pipelined CPU. Holds the PC, generates the two next-PC candidates (PC+4 and branch target) plus the select for the downstream 2:1 next-PC mux, and registers that mux's output as the new PC. It also captures the fetched instruction into the IF/ID register with stall, flush and redirect-hold handling.

## Interface
Parameters:
- WIDTH, 64, PC / address width
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC and IF/ID contents
- flush  in  1  squash the instruction entering IF/ID
- br_taken  in  1  redirect request from branch resolution
- br_target  in  WIDTH  redirect address
- instr_in  in  INSTR_W  instruction memory read data for the current pc
- next_pc  in  WIDTH  output of the downstream 2:1 next-PC mux
- pc  out  WIDTH  current PC (instruction memory address)
- pc_cand  out  [1:0][WIDTH-1:0]  mux inputs: [0] = pc+4, [1] = redirect target
- pc_sel  out  1  mux select; 1 selects pc_cand[1]
- ifid_pc  out  WIDTH  PC of the instruction held in IF/ID
- ifid_instr  out  INSTR_W  instruction held in IF/ID
- ifid_valid  out  1  IF/ID holds a live instruction

## Operation
- Reset values: pc = RESET_PC; ifid_pc = 0; ifid_instr = 0; ifid_valid = 0; pending = 0, pend_target = 0.
- Candidate generation is combinational: pc_cand[0] = pc + 4 modulo 2^WIDTH (carry out discarded); pc_cand[1] = br_taken ? br_target : pend_target; pc_sel = br_taken | pending.
- Redirect-hold FSM, two states:
  - RUN (pending = 0): if stall & br_taken, go to HELD and latch pend_target = br_target. Otherwise stay in RUN.
  - HELD (pending = 1): if stall & br_taken, stay in HELD and overwrite pend_target, so the newest target wins. If !stall, return to RUN; the redirect is consumed on this edge.
- PC update: when !stall, pc <= next_pc. When stall, pc holds. next_pc is never sampled while stalled.
- IF/ID update:
  - When !stall: ifid_pc <= pc; ifid_instr <= instr_in; ifid_valid <= !flush.
  - When stall & flush: ifid_valid <= 0; ifid_pc and ifid_instr hold.
  - When stall & !flush: everything holds.
- Branch delay slot: the instruction fetched in the same cycle a redirect is applied is still captured. Only flush squashes it.
- Simultaneous live br_taken and HELD without stall: the live br_target is used and pending clears.
- reset has priority over stall, flush and br_taken, and over any state. Asserting reset mid-redirect discards the pending redirect.

## Timing
- State latency: a redirect applied with !stall makes pc = target on the next edge. A redirect raised under stall takes effect on the first edge with stall low.
- pc_cand and pc_sel are combinational from pc, pending, pend_target, br_taken and br_target. The mux path back to next_pc must settle within one cycle; budget about 150 ps for the mux.
- ifid_* outputs lag pc by one cycle. ifid_valid first rises one edge after reset deasserts (if flush = 0).
- No combinational path from instr_in to any output.

## Test plan
- Reset with RESET_PC = 0x100: pc = 0x100, ifid_valid = 0, pc_cand[0] = 0x104, pc_sel = 0. After 3 free-running cycles: pc = 0x10C, ifid_pc = 0x108, ifid_valid = 1.
- Branch: at pc = 0x200, pulse br_taken with br_target = 0x400 for one cycle. Required: pc_sel = 1 that cycle; next pc = 0x400; ifid_pc = 0x200 (delay slot kept).
- Redirect under stall:
  - Stall 3 cycles and pulse br_taken (target 0x800) in the first stall cycle, then 0x900 in the second.
  - Required: pc constant during the stall; pending = 1; pc_sel = 1 throughout.
  - After stall drops: pc = 0x900, then pending = 0.
- Flush: flush = 1 with stall = 0 gives ifid_valid = 0 next cycle. stall = 1 & flush = 1 gives ifid_valid = 0 with ifid_instr unchanged.
- Wrap: force pc = 2^64−4. Required: pc_cand[0] = 0 and the next pc = 0.
- Reset mid-HELD: assert reset while pending = 1. Required: pending = 0, pc = RESET_PC, no redirect after release.

Source files
------------

// File: rtl/fetch_pc_stage.sv
// +--------------------------------------------------------------------------+
// | fetch_pc_stage                                                           |
// | PC register, next-PC candidate generation, redirect hold and IF/ID reg.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_pc_stage #(
  parameter int unsigned        WIDTH    = 64,
  parameter int unsigned        INSTR_W  = 32,
  parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    br_taken,
  input  logic [WIDTH-1:0]        br_target,
  input  logic [INSTR_W-1:0]      instr_in,
  input  logic [WIDTH-1:0]        next_pc,
  output logic [WIDTH-1:0]        pc,
  output logic [1:0][WIDTH-1:0]   pc_cand,
  output logic                    pc_sel,
  output logic [WIDTH-1:0]        ifid_pc,
  output logic [INSTR_W-1:0]      ifid_instr,
  output logic                    ifid_valid
);

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t           state;
  logic             pending;
  logic [WIDTH-1:0] pend_target;

  assign pending = (state == HELD);

  // A live redirect always beats a held one, so the newest target wins.
  assign pc_cand[0] = pc + PC_STEP;
  assign pc_cand[1] = br_taken ? br_target : pend_target;
  assign pc_sel     = br_taken | pending;

  // Redirect-hold FSM: remembers a redirect raised while the PC is frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pend_target <= '0;
    end else begin
      case (state)
        RUN: begin
          if (stall && br_taken) begin
            state       <= HELD;
            pend_target <= br_target;
          end
        end
        HELD: begin
          if (stall) begin
            if (br_taken) begin
              pend_target <= br_target;
            end
          end else begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (!stall) begin
      pc <= next_pc;
    end
  end

  // The delay-slot instruction is captured on a redirect; only flush kills it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_pc    <= '0;
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      ifid_pc    <= pc;
      ifid_instr <= instr_in;
      ifid_valid <= !flush;
    end else if (flush) begin
      ifid_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_stage.sv
// +--------------------------------------------------------------------------+
// | tb_fetch_pc_stage                                                        |
// | Vector-table bench for fetch_pc_stage with a post-edge scoreboard.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_pc_stage;

  localparam int W  = 64;
  localparam int IW = 32;
  localparam int NV = 24;

  logic               clk = 1'b0;
  logic               reset, stall, flush, br_taken;
  logic [W-1:0]       br_target, next_pc;
  logic [IW-1:0]      instr_in;
  logic [W-1:0]       pc, ifid_pc;
  logic [1:0][W-1:0]  pc_cand;
  logic               pc_sel, ifid_valid;
  logic [IW-1:0]      ifid_instr;
  logic               ovr;
  logic [W-1:0]       ovr_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Environment model of the downstream 2:1 mux, with an override to force a PC.
  assign next_pc = ovr ? ovr_val : (pc_sel ? pc_cand[1] : pc_cand[0]);

  fetch_pc_stage #(.WIDTH(W), .INSTR_W(IW), .RESET_PC(64'h100)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .br_taken(br_taken), .br_target(br_target), .instr_in(instr_in),
    .next_pc(next_pc), .pc(pc), .pc_cand(pc_cand), .pc_sel(pc_sel),
    .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid)
  );

  typedef struct {
    logic rst, stall, flush, br;
    logic [W-1:0] tgt;
    logic [IW-1:0] instr;
    logic ovr;
    logic [W-1:0] ovr_val;
    logic e_sel;
    logic [W-1:0] e_c0, e_c1, e_pc, e_ipc;
    logic [IW-1:0] e_iinstr;
    logic e_iv;
  } vec_t;

  typedef struct {
    int idx;
    logic [W-1:0] pc, ipc;
    logic [IW-1:0] iinstr;
    logic iv;
  } exp_t;

  vec_t vt [NV];
  exp_t sbq [$];

  function automatic vec_t mk(logic r, logic s, logic f, logic b, logic [W-1:0] t,
                              logic [IW-1:0] ins, logic o, logic [W-1:0] ov,
                              logic esel, logic [W-1:0] c0, logic [W-1:0] c1,
                              logic [W-1:0] epc, logic [W-1:0] eipc,
                              logic [IW-1:0] einstr, logic eiv);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.br = b; v.tgt = t; v.instr = ins;
    v.ovr = o; v.ovr_val = ov; v.e_sel = esel; v.e_c0 = c0; v.e_c1 = c1;
    v.e_pc = epc; v.e_ipc = eipc; v.e_iinstr = einstr; v.e_iv = eiv;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d actual %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(int idx, vec_t v);
    exp_t e;
    @(negedge clk);
    reset = v.rst; stall = v.stall; flush = v.flush; br_taken = v.br;
    br_target = v.tgt; instr_in = v.instr; ovr = v.ovr; ovr_val = v.ovr_val;
    #1;
    chk("pc_sel", idx, W'(pc_sel), W'(v.e_sel));
    chk("pc_cand0", idx, pc_cand[0], v.e_c0);
    chk("pc_cand1", idx, pc_cand[1], v.e_c1);
    sbq.push_back('{idx, v.e_pc, v.e_ipc, v.e_iinstr, v.e_iv});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("pc", e.idx, pc, e.pc);
    chk("ifid_pc", e.idx, ifid_pc, e.ipc);
    chk("ifid_instr", e.idx, W'(ifid_instr), W'(e.iinstr));
    chk("ifid_valid", e.idx, W'(ifid_valid), W'(e.iv));
  endtask

  localparam logic [W-1:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

  initial begin
    vec_t hv;
    //            rst s f b  tgt      instr o  ovr_val sel c0      c1      pc      ifid_pc ifid_i iv
    vt[0]  = mk(1, 0,0,0, 0,       'h20, 0, 0,      0, 'h104,  0,      'h100,  0,      0,     0);
    vt[1]  = mk(0, 0,0,0, 0,       'h21, 0, 0,      0, 'h104,  0,      'h104,  'h100,  'h21,  1);
    vt[2]  = mk(0, 0,0,0, 0,       'h22, 0, 0,      0, 'h108,  0,      'h108,  'h104,  'h22,  1);
    vt[3]  = mk(0, 0,0,0, 0,       'h23, 0, 0,      0, 'h10C,  0,      'h10C,  'h108,  'h23,  1);
    vt[4]  = mk(0, 0,0,0, 0,       'h24, 1, 'h200,  0, 'h110,  0,      'h200,  'h10C,  'h24,  1);
    vt[5]  = mk(0, 0,0,1, 'h400,   'h25, 0, 0,      1, 'h204,  'h400,  'h400,  'h200,  'h25,  1);
    vt[6]  = mk(0, 0,0,0, 0,       'h26, 0, 0,      0, 'h404,  0,      'h404,  'h400,  'h26,  1);
    vt[7]  = mk(0, 1,0,1, 'h800,   'h27, 0, 0,      1, 'h408,  'h800,  'h404,  'h400,  'h26,  1);
    vt[8]  = mk(0, 1,0,1, 'h900,   'h28, 0, 0,      1, 'h408,  'h900,  'h404,  'h400,  'h26,  1);
    vt[9]  = mk(0, 1,0,0, 0,       'h29, 0, 0,      1, 'h408,  'h900,  'h404,  'h400,  'h26,  1);
    vt[10] = mk(0, 0,0,0, 0,       'h2A, 0, 0,      1, 'h408,  'h900,  'h900,  'h404,  'h2A,  1);
    vt[11] = mk(0, 0,0,0, 0,       'h2B, 0, 0,      0, 'h904,  'h900,  'h904,  'h900,  'h2B,  1);
    vt[12] = mk(0, 0,1,0, 0,       'h2C, 0, 0,      0, 'h908,  'h900,  'h908,  'h904,  'h2C,  0);
    vt[13] = mk(0, 0,0,0, 0,       'h2D, 0, 0,      0, 'h90C,  'h900,  'h90C,  'h908,  'h2D,  1);
    vt[14] = mk(0, 1,1,0, 0,       'h2E, 0, 0,      0, 'h910,  'h900,  'h90C,  'h908,  'h2D,  0);
    vt[15] = mk(0, 0,0,0, 0,       'h2F, 0, 0,      0, 'h910,  'h900,  'h910,  'h90C,  'h2F,  1);
    vt[16] = mk(0, 0,0,0, 0,       'h30, 1, TOP,    0, 'h914,  'h900,  TOP,    'h910,  'h30,  1);
    vt[17] = mk(0, 0,0,0, 0,       'h31, 0, 0,      0, 0,      'h900,  0,      TOP,    'h31,  1);
    vt[18] = mk(0, 1,0,1, 'hA00,   'h32, 0, 0,      1, 'h4,    'hA00,  0,      TOP,    'h31,  1);
    vt[19] = mk(0, 0,0,1, 'hB00,   'h33, 0, 0,      1, 'h4,    'hB00,  'hB00,  0,      'h33,  1);
    vt[20] = mk(0, 0,0,0, 0,       'h34, 0, 0,      0, 'hB04,  'hA00,  'hB04,  'hB00,  'h34,  1);
    vt[21] = mk(0, 1,0,1, 'hC00,   'h35, 0, 0,      1, 'hB08,  'hC00,  'hB04,  'hB00,  'h34,  1);
    vt[22] = mk(1, 1,0,0, 0,       'h36, 0, 0,      1, 'hB08,  'hC00,  'h100,  0,      0,     0);
    vt[23] = mk(0, 0,0,0, 0,       'h37, 0, 0,      0, 'h104,  0,      'h104,  'h100,  'h37,  1);

    reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    br_target = '0; instr_in = '0; ovr = 1'b0; ovr_val = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) apply(i, vt[i]);

    // Long stall with a garbage next_pc: the PC must ignore it until released.
    for (int k = 0; k < 3; k++) begin
      hv = mk(0, 1, 0, 0, 0, 'h40, 1, {$urandom, $urandom}, 0, 'h108, 0,
              'h104, 'h100, 'h37, 1);
      apply(100 + k, hv);
    end
    hv = mk(0, 0, 0, 0, 0, 'h41, 0, 0, 0, 'h108, 0, 'h108, 'h104, 'h41, 1);
    apply(103, hv);

    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain leftover %0d expected 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
